// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - playfield constants, direction codes and paddle position helpers
package pong_pkg;

  localparam int D_WIDTH    = 640;
  localparam int D_HEIGHT   = 480;
  localparam int PADDLE_A_Y = 445;
  localparam int PADDLE_B_Y = 15;

  localparam int POS_W = 12;

  // Shared with the ball stage, which decodes the same paddle motion codes.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_STOP  = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } move_state_t;

  function automatic logic [POS_W-1:0] step_right(
    input logic [POS_W-1:0] x,
    input logic [POS_W-1:0] step,
    input logic [POS_W-1:0] max_x
  );
    return ((x + step) > max_x) ? max_x : (x + step);
  endfunction

  // Compare before subtracting so a paddle near zero can never wrap around.
  function automatic logic [POS_W-1:0] step_left(
    input logic [POS_W-1:0] x,
    input logic [POS_W-1:0] step,
    input logic [POS_W-1:0] min_x
  );
    return (x < (min_x + step)) ? min_x : (x - step);
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// rtl/paddle_ctrl_if.sv - player button inputs and paddle position/draw-box outputs
interface paddle_ctrl_if;
  logic        i_ani_stb;
  logic        i_animate;
  logic        i_btn_left;
  logic        i_btn_right;
  logic [11:0] o_x;
  logic [1:0]  o_dir;
  logic [11:0] o_x1;
  logic [11:0] o_x2;
  logic [11:0] o_y1;
  logic [11:0] o_y2;

  modport master (
    output i_ani_stb, i_animate, i_btn_left, i_btn_right,
    input  o_x, o_dir, o_x1, o_x2, o_y1, o_y2
  );

  modport slave (
    input  i_ani_stb, i_animate, i_btn_left, i_btn_right,
    output o_x, o_dir, o_x1, o_x2, o_y1, o_y2
  );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stable-level counter for one button
module btn_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int              CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_btn};
      // Any return to the committed level restarts the stability window.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - two debounced buttons drive an accelerating, clamped paddle position
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int WIDTH        = 100,
  parameter int HEIGHT       = 10,
  parameter int IX           = 270,
  parameter int IY           = PADDLE_A_Y,
  parameter int MIN_X        = 40,
  parameter int MAX_X        = 540,
  parameter int DB_CYCLES    = 50000,
  parameter int ACCEL_FRAMES = 8,
  parameter int FAST_STEP    = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  paddle_ctrl_if.slave  bus
);

  localparam int HW = $clog2(ACCEL_FRAMES + 1);

  localparam logic [POS_W-1:0] MIN_P  = POS_W'(MIN_X);
  localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX_X);
  localparam logic [POS_W-1:0] FAST_P = POS_W'(FAST_STEP);
  localparam logic [POS_W-1:0] W_P    = POS_W'(WIDTH);
  localparam logic [POS_W-1:0] IX_P   = POS_W'(IX);
  localparam logic [POS_W-1:0] Y1_P   = POS_W'(IY);
  localparam logic [POS_W-1:0] Y2_P   = POS_W'(IY + HEIGHT);
  localparam logic [HW-1:0]    HOLD_MAX = HW'(ACCEL_FRAMES);

  logic lvl_left;
  logic lvl_right;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (bus.i_btn_left),
    .o_level (lvl_left)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (bus.i_btn_right),
    .o_level (lvl_right)
  );

  move_state_t      state_q, state_d;
  logic [POS_W-1:0] x_q, x_d;
  dir_t             dir_q, dir_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [POS_W-1:0] step;
  logic             move;

  assign move = bus.i_ani_stb & bus.i_animate;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      x_q     <= IX_P;
      dir_q   <= DIR_STOP;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (lvl_left && !lvl_right) begin
      state_d = ST_LEFT;
    end else if (lvl_right && !lvl_left) begin
      state_d = ST_RIGHT;
    end
  end

  // Movement acts on the already-registered state; a state change in the
  // same cycle only affects the hold counter.
  always_comb begin
    x_d    = x_q;
    dir_d  = dir_q;
    hold_d = hold_q;
    step   = (hold_q < HOLD_MAX) ? POS_W'(1) : FAST_P;

    if (move) begin
      unique case (state_q)
        ST_RIGHT: begin
          x_d   = step_right(x_q, step, MAX_P);
          dir_d = (x_q == MAX_P) ? DIR_STOP : DIR_RIGHT;
          if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_LEFT: begin
          x_d   = step_left(x_q, step, MIN_P);
          dir_d = (x_q == MIN_P) ? DIR_STOP : DIR_LEFT;
          if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: begin
          dir_d = DIR_STOP;
        end
      endcase
    end

    if (state_d != state_q) begin
      hold_d = '0;
    end
  end

  assign bus.o_x   = x_q;
  assign bus.o_dir = dir_q;
  assign bus.o_x1  = x_q;
  assign bus.o_x2  = x_q + W_P;
  assign bus.o_y1  = Y1_P;
  assign bus.o_y2  = Y2_P;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - directed scenarios for paddle_ctrl with fast debounce and acceleration
module tb_paddle_ctrl;

  localparam int DB    = 4;
  localparam int ACC   = 4;
  localparam int FAST  = 3;
  localparam int MIN_X = 40;
  localparam int MAX_X = 540;
  localparam int WIDTH = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  initial assert (MIN_X >= FAST && MAX_X + WIDTH < 4096)
    else $fatal(1, "illegal paddle parameters");

  paddle_ctrl_if bus_a ();
  paddle_ctrl_if bus_r ();
  paddle_ctrl_if bus_l ();

  paddle_ctrl #(.WIDTH(WIDTH), .IX(270), .MIN_X(MIN_X), .MAX_X(MAX_X),
                .DB_CYCLES(DB), .ACCEL_FRAMES(ACC), .FAST_STEP(FAST)) dut_a (
    .i_clk (clk), .i_rst (rst), .bus (bus_a)
  );

  paddle_ctrl #(.WIDTH(WIDTH), .IX(534), .MIN_X(MIN_X), .MAX_X(MAX_X),
                .DB_CYCLES(DB), .ACCEL_FRAMES(ACC), .FAST_STEP(FAST)) dut_r (
    .i_clk (clk), .i_rst (rst), .bus (bus_r)
  );

  paddle_ctrl #(.WIDTH(WIDTH), .IX(41), .MIN_X(MIN_X), .MAX_X(MAX_X),
                .DB_CYCLES(DB), .ACCEL_FRAMES(ACC), .FAST_STEP(FAST)) dut_l (
    .i_clk (clk), .i_rst (rst), .bus (bus_l)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_stb(input logic v);
    bus_a.i_ani_stb = v;
    bus_r.i_ani_stb = v;
    bus_l.i_ani_stb = v;
  endtask

  task automatic set_anim(input logic v);
    bus_a.i_animate = v;
    bus_r.i_animate = v;
    bus_l.i_animate = v;
  endtask

  // One frame: nine quiet cycles then a single-cycle strobe.
  task automatic frame();
    set_stb(1'b0);
    tick(9);
    set_stb(1'b1);
    tick(1);
    set_stb(1'b0);
  endtask

  task automatic test_reset();
    set_stb(1'b0);
    set_anim(1'b1);
    bus_a.i_btn_left = 1'b0; bus_a.i_btn_right = 1'b0;
    bus_r.i_btn_left = 1'b0; bus_r.i_btn_right = 1'b0;
    bus_l.i_btn_left = 1'b0; bus_l.i_btn_right = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_checks++; if (bus_a.o_x !== 12'd270) begin n_fail++; $display("FAIL reset_x got %0d want 270", bus_a.o_x); end
    n_checks++; if (bus_a.o_dir !== 2'd2) begin n_fail++; $display("FAIL reset_dir got %0d want 2", bus_a.o_dir); end
    n_checks++; if (bus_a.o_x1 !== 12'd270) begin n_fail++; $display("FAIL reset_x1 got %0d want 270", bus_a.o_x1); end
    n_checks++; if (bus_a.o_x2 !== 12'd370) begin n_fail++; $display("FAIL reset_x2 got %0d want 370", bus_a.o_x2); end
    n_checks++; if (bus_a.o_y1 !== 12'd445) begin n_fail++; $display("FAIL reset_y1 got %0d want 445", bus_a.o_y1); end
    n_checks++; if (bus_a.o_y2 !== 12'd455) begin n_fail++; $display("FAIL reset_y2 got %0d want 455", bus_a.o_y2); end
    n_checks++; if (bus_r.o_x !== 12'd534) begin n_fail++; $display("FAIL reset_x_r got %0d want 534", bus_r.o_x); end
    n_checks++; if (bus_l.o_x !== 12'd41) begin n_fail++; $display("FAIL reset_x_l got %0d want 41", bus_l.o_x); end
  endtask

  task automatic test_glitch();
    bus_a.i_btn_right = 1'b1;
    tick(3);
    bus_a.i_btn_right = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frame();
      n_checks++; if (bus_a.o_x !== 12'd270) begin n_fail++; $display("FAIL glitch_x[%0d] got %0d want 270", i, bus_a.o_x); end
      n_checks++; if (bus_a.o_dir !== 2'd2) begin n_fail++; $display("FAIL glitch_dir[%0d] got %0d want 2", i, bus_a.o_dir); end
    end
  endtask

  task automatic test_accel_right();
    logic [11:0] exp_x [6];
    exp_x = '{12'd271, 12'd272, 12'd273, 12'd274, 12'd277, 12'd280};
    bus_a.i_btn_right = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame();
      n_checks++; if (bus_a.o_x !== exp_x[i]) begin n_fail++; $display("FAIL accel_x[%0d] got %0d want %0d", i, bus_a.o_x, exp_x[i]); end
      n_checks++; if (bus_a.o_dir !== 2'd0) begin n_fail++; $display("FAIL accel_dir[%0d] got %0d want 0", i, bus_a.o_dir); end
    end
    bus_a.i_btn_right = 1'b0;
    frame();
    n_checks++; if (bus_a.o_x !== 12'd280) begin n_fail++; $display("FAIL release_x got %0d want 280", bus_a.o_x); end
    n_checks++; if (bus_a.o_dir !== 2'd2) begin n_fail++; $display("FAIL release_dir got %0d want 2", bus_a.o_dir); end
  endtask

  task automatic test_right_clamp();
    logic [11:0] exp_x [6];
    logic [1:0]  exp_d [6];
    exp_x = '{12'd535, 12'd536, 12'd537, 12'd538, 12'd540, 12'd540};
    exp_d = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    bus_r.i_btn_right = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame();
      n_checks++; if (bus_r.o_x !== exp_x[i]) begin n_fail++; $display("FAIL rclamp_x[%0d] got %0d want %0d", i, bus_r.o_x, exp_x[i]); end
      n_checks++; if (bus_r.o_dir !== exp_d[i]) begin n_fail++; $display("FAIL rclamp_dir[%0d] got %0d want %0d", i, bus_r.o_dir, exp_d[i]); end
    end
    bus_r.i_btn_right = 1'b0;
  endtask

  task automatic test_left_clamp();
    bus_l.i_btn_left = 1'b1;
    frame();
    n_checks++; if (bus_l.o_x !== 12'd40) begin n_fail++; $display("FAIL lclamp_x0 got %0d want 40", bus_l.o_x); end
    n_checks++; if (bus_l.o_dir !== 2'd1) begin n_fail++; $display("FAIL lclamp_dir0 got %0d want 1", bus_l.o_dir); end
    frame();
    n_checks++; if (bus_l.o_x !== 12'd40) begin n_fail++; $display("FAIL lclamp_x1 got %0d want 40", bus_l.o_x); end
    n_checks++; if (bus_l.o_dir !== 2'd2) begin n_fail++; $display("FAIL lclamp_dir1 got %0d want 2", bus_l.o_dir); end
    bus_l.i_btn_left = 1'b0;
  endtask

  task automatic test_both_buttons();
    bus_a.i_btn_left  = 1'b1;
    bus_a.i_btn_right = 1'b1;
    for (int i = 0; i < 2; i++) begin
      frame();
      n_checks++; if (bus_a.o_x !== 12'd280) begin n_fail++; $display("FAIL both_x[%0d] got %0d want 280", i, bus_a.o_x); end
      n_checks++; if (bus_a.o_dir !== 2'd2) begin n_fail++; $display("FAIL both_dir[%0d] got %0d want 2", i, bus_a.o_dir); end
    end
  endtask

  task automatic test_switch_and_freeze();
    logic [11:0] exp_x [5];
    exp_x = '{12'd279, 12'd278, 12'd277, 12'd276, 12'd273};
    bus_a.i_btn_right = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frame();
      n_checks++; if (bus_a.o_x !== exp_x[i]) begin n_fail++; $display("FAIL left_x[%0d] got %0d want %0d", i, bus_a.o_x, exp_x[i]); end
      n_checks++; if (bus_a.o_dir !== 2'd1) begin n_fail++; $display("FAIL left_dir[%0d] got %0d want 1", i, bus_a.o_dir); end
    end
    set_anim(1'b0);
    for (int i = 0; i < 2; i++) begin
      frame();
      n_checks++; if (bus_a.o_x !== 12'd273) begin n_fail++; $display("FAIL freeze_x[%0d] got %0d want 273", i, bus_a.o_x); end
      n_checks++; if (bus_a.o_dir !== 2'd1) begin n_fail++; $display("FAIL freeze_dir[%0d] got %0d want 1", i, bus_a.o_dir); end
    end
    set_anim(1'b1);
    bus_a.i_btn_left  = 1'b0;
    bus_a.i_btn_right = 1'b1;
    frame();
    n_checks++; if (bus_a.o_x !== 12'd274) begin n_fail++; $display("FAIL switch_x got %0d want 274", bus_a.o_x); end
    n_checks++; if (bus_a.o_dir !== 2'd0) begin n_fail++; $display("FAIL switch_dir got %0d want 0", bus_a.o_dir); end
  endtask

  task automatic test_reset_on_strobe();
    set_stb(1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    set_stb(1'b0);
    n_checks++; if (bus_a.o_x !== 12'd270) begin n_fail++; $display("FAIL rst_stb_x got %0d want 270", bus_a.o_x); end
    n_checks++; if (bus_a.o_dir !== 2'd2) begin n_fail++; $display("FAIL rst_stb_dir got %0d want 2", bus_a.o_dir); end
    n_checks++; if (bus_a.o_x2 !== 12'd370) begin n_fail++; $display("FAIL rst_stb_x2 got %0d want 370", bus_a.o_x2); end
    bus_a.i_btn_right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_accel_right();
    test_right_clamp();
    test_left_clamp();
    test_both_buttons();
    test_switch_and_freeze();
    test_reset_on_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Upstream of the ball stage: turns two raw player buttons into a paddle left-edge position and a motion code.
- Outputs feed the ball's paddle x / paddle dir collision inputs and the draw logic.
- One instance per player: A at the bottom, B at the top. They differ only by the IY parameter.
- Contains input synchronisers, debounce counters, a move FSM and an acceleration counter.

Parameters:
- WIDTH, 100: paddle width in px. x is the left edge; the ball-collision span is x..x+WIDTH.
- HEIGHT, 10: paddle height in px.
- IX, 270: reset left-edge position.
- IY, 445: top edge. Use 445 for paddle A; use 15 for paddle B.
- MIN_X, 40: lowest legal left edge.
- MAX_X, 540: highest legal left edge.
- DB_CYCLES, 50000: number of i_clk cycles a synced button must stay stable before it is accepted.
- ACCEL_FRAMES, 8: number of strobes at 1 px before switching to fast speed.
- FAST_STEP, 3: px per strobe after acceleration.

Ports:
- i_clk, in, 1: base clock.
- i_rst, in, 1: reset; synchronous, active-high.
- i_ani_stb, in, 1: animation strobe, one i_clk-cycle pulse per frame.
- i_animate, in, 1: movement enabled while high.
- i_btn_left, in, 1: raw asynchronous button, active-high.
- i_btn_right, in, 1: raw asynchronous button, active-high.
- o_x, out, 12: paddle left edge.
- o_dir, out, 2: motion code. 0 = moving right (+x), 1 = moving left (-x), 2 = stationary, 3 = never driven.
- o_x1, o_x2, o_y1, o_y2, out, 12 each: draw box. x1=o_x, x2=o_x+WIDTH, y1=IY, y2=IY+HEIGHT. Combinational from o_x.

Behaviour:
- Reset, checked on i_clk edge when i_rst=1, overrides everything:
  - o_x=IX, o_dir=2, FSM=IDLE.
  - Hold counter=0.
  - Sync flops=0, debounced levels=0, debounce counters=0.
- Synchroniser: two-flop chain per button.
- Debounce, per button:
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments each cycle.
  - When the counter reaches DB_CYCLES-1 it commits the new debounced level and clears.
  - A glitch shorter than DB_CYCLES cycles never changes the debounced level.
  - Counter width is $clog2(DB_CYCLES+1).
  - Latency from raw edge to debounced edge is 2+DB_CYCLES cycles.
- FSM states IDLE, LEFT, RIGHT. Evaluated every i_clk cycle from the debounced levels L and R:
  - L&~R goes to LEFT.
  - R&~L goes to RIGHT.
  - Neither pressed, or both pressed, goes to IDLE.
  - Any state change clears the hold counter.
- Movement happens only on cycles where i_ani_stb && i_animate, and uses the state registered before that cycle.
  - step = 1 while hold < ACCEL_FRAMES, otherwise FAST_STEP.
  - In LEFT or RIGHT, hold increments and saturates at ACCEL_FRAMES.
  - RIGHT: o_x <= min(o_x+step, MAX_X).
  - LEFT: if o_x < MIN_X+step then o_x <= MIN_X, else o_x <= o_x-step. This compare-first form prevents underflow.
  - IDLE: o_x unchanged.
- o_dir is registered and updated on the same movement cycle:
  - 2 if the state is IDLE.
  - 2 if the paddle is already pinned at the limit in its direction of travel (o_x==MAX_X in RIGHT, o_x==MIN_X in LEFT).
  - Otherwise 0 for RIGHT, 1 for LEFT.
  - The clamp step that lands exactly on the limit still reports motion. The next strobe reports 2.
- i_animate=0: o_x, o_dir and hold are frozen. The FSM and debounce keep tracking the buttons.
- i_ani_stb without i_animate has no effect.
- Reset asserted mid-movement: the next cycle shows the reset values, and the strobe in that same cycle is ignored.
- Arithmetic: all position math is 12-bit unsigned. MIN_X >= FAST_STEP and MAX_X+WIDTH < 4096 are parameter legality rules. The bench checks them with an initial assertion.

Decomposition:
- Shared package pong_pkg:
  - Direction codes DIR_RIGHT=0, DIR_LEFT=1, DIR_STOP=2. The ball stage uses the same codes.
  - Playfield constants: D_WIDTH=640, D_HEIGHT=480, PADDLE_A_Y=445, PADDLE_B_Y=15.
- Sub-module btn_debounce (parameter DB_CYCLES; ports i_clk, i_rst, i_btn, o_level): holds the two-flop sync and the stable counter. Instantiated twice.

Test Plan:
All scenarios use DB_CYCLES=4, ACCEL_FRAMES=4, FAST_STEP=3, and a strobe every 10 cycles with i_animate=1.
- Reset check: after reset, o_x=270, o_dir=2, o_x2=370, o_y1=445, o_y2=455.
- Glitch rejection: a 3-cycle pulse on i_btn_right leaves o_x at 270 and o_dir at 2 across the next 5 strobes.
- Acceleration right: hold right for 6 strobes. o_x goes 271, 272, 273, 274, 277, 280, with o_dir=0 from the first move. On release, after the debounce delay, o_dir=2 on the next strobe and o_x stays at 280.
- Right clamp: start at o_x=538 in fast mode. The next strobe gives 540 with o_dir=0. The following strobe gives 540 with o_dir=2.
- Left clamp: hold left from IX=41 with the parameter override. The first strobe gives 40 with o_dir=1. The next gives 40 with o_dir=2, and there is no wrap to 4095.
- Both buttons, freeze and reset:
  - Both pressed: o_dir=2 and o_x is static.
  - Switching from left to right clears hold, so the first right step is 1 px.
  - i_animate=0 with left held: o_x is frozen.
  - i_rst pulsed on a strobe cycle: o_x=270 and o_dir=2 on the next cycle.
